mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that responds to the CPU's data-memory port alongside `data_mem`. The CPU stores bytes to a TXDATA register; the block buffers them in a small FIFO and serializes them as 8N1 frames on `tx`. It decodes its own two-word window. The integration mux steers `d_out` back to the CPU whenever `sel` is high.

## Interface
Parameters:
- `BASE_ADR`, 32'h0000_1000, word-aligned base of the 2-word register window
- `CLKS_PER_BIT`, 16, clock cycles per serial bit (≥2)
- `FIFO_DEPTH`, 8, TX FIFO entries (power of two, ≥2)

Ports:
- `clk` input 1, sole clock; all state updates on posedge
- `rst` input 1, synchronous, active-high reset
- `adr` input 32, CPU data address
- `d_in` input 32, CPU store data
- `mrd` input 1, CPU load strobe
- `mwr` input 1, CPU store strobe
- `d_out` output 32, load data (combinational)
- `sel` output 1, `adr` falls in window (combinational)
- `tx` output 1, serial line, idle high

## Operation
Register map, word offsets:
- BASE+0 TXDATA: write pushes `d_in[7:0]`; read returns 0
- BASE+4 STATUS: read returns `{27'b0, cnt_nonzero_hi, ovf, busy, empty, full}`
  - bit4 = FIFO count ≥ FIFO_DEPTH/2
  - write with `d_in[3]`=1 clears `ovf`

Decode rules:
- `sel` = (`adr[31:3]` == `BASE_ADR[31:3]`); `adr[1:0]` ignored
- `d_out` = register value when `sel && mrd`, else 32'h0
- Store accepted on posedge when `mwr && sel`

FIFO rules:
- Push to TXDATA while full: byte dropped, `ovf` set (sticky)
- Push while full, same edge as a pop: byte accepted, count unchanged, `ovf` not set
- Push and pop when not full: count unchanged

Transmitter FSM, states IDLE, START, DATA, STOP:
- IDLE: `tx`=1. If FIFO non-empty, pop into shift register, load baud counter with CLKS_PER_BIT-1, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. At expiry, if FIFO non-empty, pop and go to START with no idle gap; otherwise go to IDLE.

Other rules:
- `busy` = state ≠ IDLE
- Baud counter is 16 bits and counts down; it reloads at 0.
- Bit index is 3 bits; it wraps to 0 on transition to STOP.

## Timing
- Reset values:
  - `tx`=1, state IDLE, FIFO empty (`empty`=1, `full`=0), `ovf`=0
  - `d_out`=0 unless a load is addressed, in which case STATUS reads 32'h2
- Push latency: store at edge N into an idle block → pop and `tx`=0 after edge N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- `tx` is driven from a register: glitch-free, changes only on posedge.
- Reset asserted mid-frame: at the next edge `tx`=1, FIFO flushed, `ovf` cleared, state IDLE. No partial frame resumes.
- A STATUS write with `d_in[3]`=1 and an overflow push on the same edge: the set wins, so `ovf`=1.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - FSM gains state PARITY between DATA and STOP
  - `tx` = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles
  - Frame = 11·CLKS_PER_BIT cycles
- Undefined: no PARITY state, 10-bit frame as above.

## Structure
Shared package `uart_tx_pkg`:
- state enum
- register offsets (`TXDATA_OFS`=0, `STATUS_OFS`=4)
- STATUS bit positions

Sub-module `tx_fifo`:
- synchronous FIFO with push, pop, dout, full, empty, half
- width 8, depth FIFO_DEPTH
- first-word-fall-through `dout`

Top level holds decode, STATUS, the FSM and the baud counter.

## Test plan
- Reset, then read STATUS → `d_out`=32'h2 and `tx`=1 throughout 100 cycles.
- Store 0x55 to BASE, CLKS_PER_BIT=16 → `tx` low for 16 cycles, then 1,0,1,0,1,0,1,0 with 16 cycles each, then high 16; STATUS returns to 32'h2 after 160 cycles.
- Store 0xA5 then 0x3C on consecutive cycles → two contiguous frames totalling 320 cycles, no idle gap; decoded bytes are 0xA5 then 0x3C.
- Hold TX busy and store 10 bytes (FIFO_DEPTH=8) → STATUS shows `full`=1 and `ovf`=1. Write STATUS with 32'h8 → `ovf`=0. Exactly 9 frames are emitted.
- Assert `rst` for one cycle during DATA bit 3 → `tx`=1 at the next edge, STATUS=32'h2, no further frames.
- With `UART_TX_PARITY_EN`, store 0x07 → parity bit 1 after the data bits; frame is 176 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module  : uart_tx_pkg
// Brief   : Shared types and register map for the MMIO UART transmitter.
// Config  : UART_TX_PARITY_EN adds the PARITY state
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_HALF  = 4;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_fifo.sv
// ============================================================================
// Module  : tx_fifo
// Brief   : Synchronous first-word-fall-through FIFO with full/empty/half flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             half
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_HALF  = (AW+1)'(DEPTH / 2);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (count_q == c_DEPTH);
    assign empty = (count_q == '0);
    assign half  = (count_q >= c_HALF);
    assign dout  = mem_q[rd_ptr_q];

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module  : mmio_uart_tx
// Brief   : Memory-mapped 8N1 UART transmitter with TXDATA/STATUS registers.
// Config  : UART_TX_PARITY_EN adds an even-parity bit before the stop bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADR     = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] d_in,
    input  logic        mrd,
    input  logic        mwr,
    output logic [31:0] d_out,
    output logic        sel,
    output logic        tx
);

    localparam logic [15:0] c_BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic [2:0]  w_reg_ofs;
    logic        w_wr;
    logic        w_push;
    logic        w_stat_wr;
    logic        w_pop;
    logic        w_ovf_evt;
    logic        w_baud_done;
    logic        w_busy;
    logic [31:0] w_status;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_half;
    logic        w_unused_bits;

    assign sel       = (adr[31:3] == BASE_ADR[31:3]);
    assign w_reg_ofs = {adr[2], 2'b00};
    assign w_wr      = mwr && sel;
    assign w_push    = w_wr && (w_reg_ofs == TXDATA_OFS);
    assign w_stat_wr = w_wr && (w_reg_ofs == STATUS_OFS);
    assign w_ovf_evt = w_push && w_fifo_full && !w_pop;

    assign w_unused_bits = ^{adr[1:0], d_in[31:8]};

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (d_in[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .half  (w_fifo_half)
    );

    always_comb begin
        w_status             = 32'h0;
        w_status[STAT_FULL]  = w_fifo_full;
        w_status[STAT_EMPTY] = w_fifo_empty;
        w_status[STAT_BUSY]  = w_busy;
        w_status[STAT_OVF]   = ovf_q;
        w_status[STAT_HALF]  = w_fifo_half;
    end

    always_comb begin
        d_out = 32'h0;
        if (sel && mrd && (w_reg_ofs == STATUS_OFS)) begin
            d_out = w_status;
        end
    end

    // Set is evaluated last so an overflow on the clearing edge still sticks
    always_comb begin
        ovf_d = ovf_q;
        if (w_stat_wr && d_in[3]) begin
            ovf_d = 1'b0;
        end
        if (w_ovf_evt) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign w_baud_done = (baud_q == 16'd0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != ST_IDLE) begin
            baud_d = w_baud_done ? c_BAUD_RELOAD : (baud_q - 16'd1);
        end
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_fifo_dout;
                    baud_d  = c_BAUD_RELOAD;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(w_fifo_dout);
`endif
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_done) begin
                    if (!w_fifo_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_fifo_dout;
                        state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                        par_d   = even_parity(w_fifo_dout);
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the upcoming state so tx changes on the same edge as the FSM
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign w_busy = (state_q != ST_IDLE);
    assign tx     = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module  : tb_mmio_uart_tx
// Brief   : Scoreboard bench for mmio_uart_tx; a serial monitor decodes frames.
// Config  : UART_TX_PARITY_EN expects an even-parity bit in each frame
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          CPB  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif
    localparam int          FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = 32'h0;
    logic [31:0] d_in = 32'h0;
    logic        mrd = 1'b0;
    logic        mwr = 1'b0;
    logic [31:0] d_out;
    logic        sel;
    logic        tx;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          frames_done = 0;
    logic [7:0]  sb[$];
    int          starts[$];

    mmio_uart_tx #(
        .BASE_ADR     (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .adr   (adr),
        .d_in  (d_in),
        .mrd   (mrd),
        .mwr   (mwr),
        .d_out (d_out),
        .sel   (sel),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        adr = a;
        d_in = d;
        mwr = 1'b1;
        @(posedge clk);
        #1;
        mwr = 1'b0;
        adr = 32'h0;
        d_in = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        adr = a;
        mrd = 1'b1;
        #2;
        v = d_out;
        mrd = 1'b0;
        adr = 32'h0;
    endtask

    task automatic wait_neg(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // Serial monitor: decodes each frame mid-bit and checks it against the scoreboard
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       ab;
        logic       p;
        logic       stp;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0;
                b = 8'h0;
                p = 1'b0;
                wait_neg(CPB / 2 - 1, ab);
                if (!ab) chk("start_bit", {31'b0, tx}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    wait_neg(CPB, ab);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                wait_neg(CPB, ab);
                p = tx;
`endif
                wait_neg(CPB, ab);
                stp = tx;
                if (!ab) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%0h required=none", b);
                    end else begin
                        e = sb.pop_front();
                        chk("rx_byte", {24'b0, b}, {24'b0, e});
`ifdef UART_TX_PARITY_EN
                        chk("rx_parity", {31'b0, p}, {31'b0, ^e});
`endif
                    end
                    chk("stop_bit", {31'b0, stp}, 32'h1);
                    frames_done++;
                end
            end
        end
    end

    initial begin : main
        logic [31:0] v;
        int          f0;
        int          s0;
        int          bad;

        tick(3);
        rd(BASE + 32'h4, v);
        chk("reset_status", v, 32'h2);
        chk("reset_tx", {31'b0, tx}, 32'h1);
        rst = 1'b0;
        tick(1);

        // Decode and read-back
        adr = BASE + 32'h4;
        #1;
        chk("dout_no_mrd", d_out, 32'h0);
        chk("sel_in_window", {31'b0, sel}, 32'h1);
        adr = BASE + 32'h8;
        #1;
        chk("sel_above", {31'b0, sel}, 32'h0);
        adr = BASE - 32'h4;
        #1;
        chk("sel_below", {31'b0, sel}, 32'h0);
        adr = 32'h0;
        rd(BASE + 32'h7, v);
        chk("status_low_bits_ignored", v, 32'h2);
        rd(BASE, v);
        chk("txdata_read_zero", v, 32'h0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        chk("idle_tx_high_100", bad, 0);

        // Single frame: latency and length
        f0 = frames_done;
        sb.push_back(8'h55);
        st(BASE, 32'h55);
        chk("latency_edgeN", {31'b0, tx}, 32'h1);
        tick(1);
        chk("latency_edgeN1", {31'b0, tx}, 32'h0);
        rd(BASE + 32'h4, v);
        chk("busy_status", v, 32'h6);
        tick(FRAME_CYC - 1);
        rd(BASE + 32'h4, v);
        chk("frame_last_cycle_busy", v, 32'h6);
        tick(1);
        rd(BASE + 32'h4, v);
        chk("frame_end_idle", v, 32'h2);
        chk("frames_single", frames_done - f0, 1);

        // Back-to-back frames
        f0 = frames_done;
        s0 = starts.size();
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        st(BASE, 32'hA5);
        st(BASE, 32'h3C);
        tick(2 * FRAME_CYC - 1);
        rd(BASE + 32'h4, v);
        chk("b2b_busy", v, 32'h6);
        tick(1);
        rd(BASE + 32'h4, v);
        chk("b2b_idle", v, 32'h2);
        chk("frames_b2b", frames_done - f0, 2);
        if (starts.size() >= s0 + 2) begin
            chk("b2b_no_gap", starts[s0 + 1] - starts[s0], FRAME_CYC);
        end else begin
            checks++;
            failures++;
            $display("FAIL b2b_no_gap actual=%0d starts required=2", starts.size() - s0);
        end

        // Overflow, clear, and push-while-full on the pop edge
        f0 = frames_done;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) sb.push_back(8'h10 + 8'(k));
            st(BASE, 32'h10 + k);
        end
        rd(BASE + 32'h4, v);
        chk("ovf_status", v, 32'h1D);
        st(BASE + 32'h4, 32'h8);
        rd(BASE + 32'h4, v);
        chk("ovf_cleared", v, 32'h15);
        tick(FRAME_CYC - 10);
        rd(BASE + 32'h4, v);
        chk("full_before_pop", v, 32'h15);
        sb.push_back(8'h5A);
        st(BASE, 32'h5A);
        rd(BASE + 32'h4, v);
        chk("push_on_pop_full", v, 32'h15);
        tick(9 * FRAME_CYC);
        rd(BASE + 32'h4, v);
        chk("drain_idle", v, 32'h2);
        chk("frames_overflow", frames_done - f0, 10);
        chk("sb_drained", sb.size(), 0);

        // Reset during data bit 3
        f0 = frames_done;
        sb.push_back(8'hF0);
        st(BASE, 32'hF0);
        tick(1 + 4 * CPB + 5);
        chk("bit3_low", {31'b0, tx}, 32'h0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("reset_mid_tx", {31'b0, tx}, 32'h1);
        sb.delete();
        rd(BASE + 32'h4, v);
        chk("reset_mid_status", v, 32'h2);
        bad = 0;
        repeat (2 * FRAME_CYC) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        chk("reset_no_resume", bad, 0);
        chk("frames_after_reset", frames_done - f0, 0);

        // Odd-parity-weight byte
        f0 = frames_done;
        sb.push_back(8'h07);
        st(BASE, 32'h07);
        tick(1);
        chk("x07_start", {31'b0, tx}, 32'h0);
        tick(FRAME_CYC - 1);
        rd(BASE + 32'h4, v);
        chk("x07_last_busy", v, 32'h6);
        tick(1);
        rd(BASE + 32'h4, v);
        chk("x07_idle", v, 32'h2);
        chk("frames_x07", frames_done - f0, 1);

        chk("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
